// File: rtl/fwd_track_unit.sv
// Operand forwarding with per-pipe in-flight result tracking and a write-back register per pipe.
// Each read slot gets the youngest matching producer's data, or a RAW hazard flag if that producer is not ready.
module fwd_track_unit #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int NPIPE  = 2,
    parameter int NSRC   = 3,
    parameter int DEPTH  = 7,
    parameter int LAT_W  = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NPIPE-1:0]               iss_valid,
    input  logic [NPIPE-1:0]               iss_wr_en,
    input  logic [NPIPE*ADDR_W-1:0]        iss_addr,
    input  logic [NPIPE*LAT_W-1:0]         iss_lat,
    input  logic [NPIPE-1:0]               res_valid,
    input  logic [NPIPE*DATA_W-1:0]        res_data,
    input  logic [NPIPE*NSRC*ADDR_W-1:0]   src_addr,
    input  logic [NPIPE*NSRC*DATA_W-1:0]   src_rf_data,
    output logic [NPIPE*NSRC*DATA_W-1:0]   src_data,
    output logic [NPIPE*NSRC-1:0]          src_hazard,
    output logic [NPIPE-1:0]               wb_en,
    output logic [NPIPE*ADDR_W-1:0]        wb_addr,
    output logic [NPIPE*DATA_W-1:0]        wb_data,
    output logic                           err
);
    localparam int NSLOT = NPIPE * NSRC;
    localparam int LAST  = DEPTH - 1;

    // Index i holds stage i+1.
    logic              v_q    [NPIPE][DEPTH];
    logic              v_d    [NPIPE][DEPTH];
    logic [ADDR_W-1:0] addr_q [NPIPE][DEPTH];
    logic [ADDR_W-1:0] addr_d [NPIPE][DEPTH];
    logic [LAT_W-1:0]  lat_q  [NPIPE][DEPTH];
    logic [LAT_W-1:0]  lat_d  [NPIPE][DEPTH];
    logic              rdy_q  [NPIPE][DEPTH];
    logic              rdy_d  [NPIPE][DEPTH];
    logic [DATA_W-1:0] data_q [NPIPE][DEPTH];
    logic [DATA_W-1:0] data_d [NPIPE][DEPTH];
    logic [NPIPE-1:0]  wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q [NPIPE];
    logic [ADDR_W-1:0] wb_addr_d [NPIPE];
    logic [DATA_W-1:0] wb_data_q [NPIPE];
    logic [DATA_W-1:0] wb_data_d [NPIPE];
    logic              err_q, err_d;

    logic              match [NPIPE][DEPTH];
    logic              cap   [NPIPE][DEPTH];

    always_comb begin
        int unsigned cnt;
        logic [LAT_W-1:0] lat_in;
        logic lat_ok;
        logic last_rdy;
        err_d = err_q;
        for (int p = 0; p < NPIPE; p++) begin
            // A result is captured only when exactly one entry sits at its latency stage.
            cnt = 0;
            for (int i = 0; i < DEPTH; i++) begin
                match[p][i] = v_q[p][i] && (lat_q[p][i] == LAT_W'(i + 1));
                if (match[p][i]) cnt++;
            end
            if (res_valid[p] && cnt != 1) err_d = 1'b1;
            for (int i = 0; i < DEPTH; i++)
                cap[p][i] = match[p][i] && res_valid[p] && (cnt == 1);

            for (int i = 1; i < DEPTH; i++) begin
                v_d[p][i]    = v_q[p][i-1];
                addr_d[p][i] = addr_q[p][i-1];
                lat_d[p][i]  = lat_q[p][i-1];
                rdy_d[p][i]  = rdy_q[p][i-1] | cap[p][i-1];
                data_d[p][i] = cap[p][i-1] ? res_data[p*DATA_W +: DATA_W] : data_q[p][i-1];
            end

            lat_in = iss_lat[p*LAT_W +: LAT_W];
            lat_ok = (lat_in != '0) &&
                     ({{(32-LAT_W){1'b0}}, lat_in} <= 32'(DEPTH));
            if (iss_valid[p] && iss_wr_en[p] && !lat_ok) err_d = 1'b1;
            v_d[p][0]    = iss_valid[p] && iss_wr_en[p] && lat_ok;
            addr_d[p][0] = iss_addr[p*ADDR_W +: ADDR_W];
            lat_d[p][0]  = lat_in;
            rdy_d[p][0]  = 1'b0;
            data_d[p][0] = '0;

            last_rdy        = rdy_q[p][LAST] | cap[p][LAST];
            wb_en_d[p]      = v_q[p][LAST] && last_rdy;
            wb_addr_d[p]    = wb_addr_q[p];
            wb_data_d[p]    = wb_data_q[p];
            if (wb_en_d[p]) begin
                wb_addr_d[p] = addr_q[p][LAST];
                wb_data_d[p] = cap[p][LAST] ? res_data[p*DATA_W +: DATA_W] : data_q[p][LAST];
            end
            if (v_q[p][LAST] && !last_rdy) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < NPIPE; p++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    v_q[p][i]    <= 1'b0;
                    addr_q[p][i] <= '0;
                    lat_q[p][i]  <= '0;
                    rdy_q[p][i]  <= 1'b0;
                    data_q[p][i] <= '0;
                end
                wb_addr_q[p] <= '0;
                wb_data_q[p] <= '0;
            end
            wb_en_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int p = 0; p < NPIPE; p++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    v_q[p][i]    <= v_d[p][i];
                    addr_q[p][i] <= addr_d[p][i];
                    lat_q[p][i]  <= lat_d[p][i];
                    rdy_q[p][i]  <= rdy_d[p][i];
                    data_q[p][i] <= data_d[p][i];
                end
                wb_addr_q[p] <= wb_addr_d[p];
                wb_data_q[p] <= wb_data_d[p];
            end
            wb_en_q <= wb_en_d;
            err_q   <= err_d;
        end
    end

    // Scan oldest to youngest, low pipe to high, so the last hit is the winner.
    always_comb begin
        logic [ADDR_W-1:0] sa;
        logic              hit;
        logic              hrdy;
        logic [DATA_W-1:0] hdata;
        src_data   = '0;
        src_hazard = '0;
        for (int k = 0; k < NSLOT; k++) begin
            sa    = src_addr[k*ADDR_W +: ADDR_W];
            hit   = 1'b0;
            hrdy  = 1'b0;
            hdata = '0;
            for (int p = 0; p < NPIPE; p++) begin
                if (wb_en_q[p] && wb_addr_q[p] == sa) begin
                    hit   = 1'b1;
                    hrdy  = 1'b1;
                    hdata = wb_data_q[p];
                end
            end
            for (int i = DEPTH - 1; i >= 0; i--) begin
                for (int p = 0; p < NPIPE; p++) begin
                    if (v_q[p][i] && addr_q[p][i] == sa) begin
                        hit   = 1'b1;
                        hrdy  = rdy_q[p][i] | cap[p][i];
                        hdata = rdy_q[p][i] ? data_q[p][i] : res_data[p*DATA_W +: DATA_W];
                    end
                end
            end
            src_hazard[k] = hit && !hrdy;
            src_data[k*DATA_W +: DATA_W] = (hit && hrdy) ? hdata : src_rf_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        wb_addr = '0;
        wb_data = '0;
        for (int p = 0; p < NPIPE; p++) begin
            wb_addr[p*ADDR_W +: ADDR_W] = wb_addr_q[p];
            wb_data[p*DATA_W +: DATA_W] = wb_data_q[p];
        end
    end

    assign wb_en = wb_en_q;
    assign err   = err_q;

endmodule

// File: tb/tb_fwd_track_unit.sv
// Directed scoreboard bench for fwd_track_unit: forwarding priority, bypass, write-back and error stickiness.
module tb_fwd_track_unit;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 7;
    localparam int NPIPE  = 2;
    localparam int NSRC   = 3;
    localparam int DEPTH  = 7;
    localparam int LAT_W  = 3;
    localparam int NSLOT  = NPIPE * NSRC;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NPIPE-1:0]          iss_valid, iss_wr_en, res_valid;
    logic [NPIPE*ADDR_W-1:0]   iss_addr;
    logic [NPIPE*LAT_W-1:0]    iss_lat;
    logic [NPIPE*DATA_W-1:0]   res_data;
    logic [NSLOT*ADDR_W-1:0]   src_addr;
    logic [NSLOT*DATA_W-1:0]   src_rf_data;
    logic [NSLOT*DATA_W-1:0]   src_data;
    logic [NSLOT-1:0]          src_hazard;
    logic [NPIPE-1:0]          wb_en;
    logic [NPIPE*ADDR_W-1:0]   wb_addr;
    logic [NPIPE*DATA_W-1:0]   wb_data;
    logic                      err;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] d2;

    fwd_track_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NPIPE(NPIPE),
        .NSRC(NSRC), .DEPTH(DEPTH), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_wr_en(iss_wr_en), .iss_addr(iss_addr), .iss_lat(iss_lat),
        .res_valid(res_valid), .res_data(res_data),
        .src_addr(src_addr), .src_rf_data(src_rf_data),
        .src_data(src_data), .src_hazard(src_hazard),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [DATA_W-1:0] obs);
        logic [DATA_W-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check_val(tag, obs, e);
    endtask

    function automatic logic [DATA_W-1:0] sdata(input int k);
        return src_data[k*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] wdata(input int p);
        return wb_data[p*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] waddr(input int p);
        return DATA_W'(wb_addr[p*ADDR_W +: ADDR_W]);
    endfunction

    task automatic clear_pulses();
        iss_valid = '0;
        iss_wr_en = '0;
        iss_addr  = '0;
        iss_lat   = '0;
        res_valid = '0;
        res_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_pulses();
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic issue(input int p, input int a, input int lat);
        iss_valid[p] = 1'b1;
        iss_wr_en[p] = 1'b1;
        iss_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
        iss_lat[p*LAT_W +: LAT_W]    = LAT_W'(lat);
    endtask

    task automatic result(input int p, input logic [DATA_W-1:0] d);
        res_valid[p] = 1'b1;
        res_data[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic set_src(input int k, input int a, input logic [DATA_W-1:0] rf);
        src_addr[k*ADDR_W +: ADDR_W]    = ADDR_W'(a);
        src_rf_data[k*DATA_W +: DATA_W] = rf;
    endtask

    task automatic expect_slot(input string tag, input int k, input logic hz, input logic [DATA_W-1:0] d);
        push_exp(DATA_W'(hz));
        push_exp(d);
        pop_check({tag, "_hz"}, DATA_W'(src_hazard[k]));
        pop_check({tag, "_data"}, sdata(k));
    endtask

    initial begin
        clear_pulses();
        src_addr    = '0;
        src_rf_data = '0;
        reset       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state and plain register-file read
        set_src(0, 5, 'hAA);
        settle();
        push_exp(0); pop_check("rst_wb_en", DATA_W'(wb_en));
        push_exp(0); pop_check("rst_err", DATA_W'(err));
        push_exp(0); pop_check("rst_hz_all", DATA_W'(src_hazard));
        push_exp('hAA); pop_check("rst_data", sdata(0));

        // Single producer, lat 2: hazard, bypass, ready entry, write-back
        d2 = {$urandom, $urandom, $urandom, $urandom};
        step();
        issue(0, 5, 2);
        step();
        settle();
        expect_slot("t2_s1", 0, 1'b1, 'hAA);
        step();
        result(0, d2);
        settle();
        expect_slot("t2_byp", 0, 1'b0, d2);
        step();
        settle();
        expect_slot("t2_s3", 0, 1'b0, d2);
        repeat (5) step();
        settle();
        push_exp(2'b01); pop_check("t2_wb_en", DATA_W'(wb_en));
        push_exp(5);     pop_check("t2_wb_addr", waddr(0));
        push_exp(d2);    pop_check("t2_wb_data", wdata(0));
        expect_slot("t2_fwd_wb", 0, 1'b0, d2);
        step();
        settle();
        push_exp(0); pop_check("t2_wb_off", DATA_W'(wb_en));
        expect_slot("t2_after", 0, 1'b0, 'hAA);

        // Younger producer in the other pipe wins
        step();
        set_src(3, 9, 'hCC);
        issue(0, 9, 6);
        step();
        issue(1, 9, 1);
        step();
        result(1, 'hB1);
        settle();
        expect_slot("t3_byp", 3, 1'b0, 'hB1);
        step();
        settle();
        expect_slot("t3_young", 3, 1'b0, 'hB1);
        repeat (3) step();
        result(0, 'hA0);
        settle();
        expect_slot("t3_c6", 3, 1'b0, 'hB1);
        repeat (2) step();
        settle();
        push_exp(2'b01); pop_check("t3_wb0_en", DATA_W'(wb_en));
        push_exp(9);     pop_check("t3_wb0_addr", waddr(0));
        push_exp('hA0);  pop_check("t3_wb0_data", wdata(0));
        expect_slot("t3_c8", 3, 1'b0, 'hB1);
        step();
        settle();
        push_exp(2'b10); pop_check("t3_wb1_en", DATA_W'(wb_en));
        push_exp('hB1);  pop_check("t3_wb1_data", wdata(1));
        step();
        settle();
        expect_slot("t3_done", 3, 1'b0, 'hCC);

        // Same stage in both pipes: higher pipe wins, both write back
        step();
        set_src(1, 3, 'hDD);
        issue(0, 3, 4);
        issue(1, 3, 4);
        step();
        settle();
        expect_slot("t4_s1", 1, 1'b1, 'hDD);
        repeat (3) step();
        result(0, 'h11);
        result(1, 'h22);
        settle();
        expect_slot("t4_byp", 1, 1'b0, 'h22);
        step();
        settle();
        expect_slot("t4_s5", 1, 1'b0, 'h22);
        repeat (3) step();
        settle();
        push_exp(2'b11); pop_check("t4_wb_en", DATA_W'(wb_en));
        push_exp(3);     pop_check("t4_wb_addr1", waddr(1));
        push_exp('h11);  pop_check("t4_wb_data0", wdata(0));
        push_exp('h22);  pop_check("t4_wb_data1", wdata(1));
        expect_slot("t4_fwd_wb", 1, 1'b0, 'h22);
        push_exp(0); pop_check("t4_err", DATA_W'(err));

        // Illegal latency and orphan result both set a sticky error
        step();
        set_src(2, 7, 'hEE);
        issue(0, 7, 0);
        step();
        settle();
        push_exp(1); pop_check("t5_lat0_err", DATA_W'(err));
        expect_slot("t5_no_entry", 2, 1'b0, 'hEE);
        apply_reset();
        settle();
        push_exp(0); pop_check("t5_rst_err", DATA_W'(err));
        step();
        result(0, 'h55);
        step();
        settle();
        push_exp(1); pop_check("t5_orphan_err", DATA_W'(err));
        repeat (4) step();
        settle();
        push_exp(1); pop_check("t5_sticky", DATA_W'(err));

        // Reset with three entries in flight
        apply_reset();
        settle();
        push_exp(0); pop_check("t6_err0", DATA_W'(err));
        step();
        set_src(0, 1, 'h101);
        set_src(1, 2, 'h102);
        set_src(2, 4, 'h104);
        issue(0, 1, 3);
        step();
        issue(1, 2, 2);
        step();
        issue(0, 4, 1);
        step();
        settle();
        push_exp(3'b111); pop_check("t6_hz_pre", DATA_W'(src_hazard[2:0]));
        reset = 1'b0;
        step();
        reset = 1'b1;
        settle();
        push_exp(0); pop_check("t6_hz_post", DATA_W'(src_hazard));
        push_exp('h101); pop_check("t6_rf0", sdata(0));
        push_exp('h104); pop_check("t6_rf2", sdata(2));
        for (int c = 0; c < 10; c++) begin
            step();
            settle();
            push_exp(0); pop_check("t6_no_wb", DATA_W'(wb_en));
        end
        push_exp(0); pop_check("t6_err_end", DATA_W'(err));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
